t07_mem_arbiter: RTL and testbench

T07_MEM_ARBITER -- requirements
Module: t07_mem_arbiter

---
 rtl/t07_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_t07_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t07_mem_arbiter.sv
// Round-robin arbiter between a fetch port and a data port sharing one memory port.
// One access is outstanding at a time; completion is the memory's busy falling edge, else a timeout.
module t07_mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   input  logic        d_req,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic        mem_busy,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  mem_rwi,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        f_done,
   output logic        d_done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        active
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic [1:0] RWI_READ    = 2'b10;
   localparam logic [1:0] RWI_WRITE   = 2'b01;
   localparam logic [1:0] RWI_FETCH   = 2'b11;
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;   // 1 = data side owns the access
   logic        last_q, last_d;     // 1 = data side was granted last
   logic [1:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        prev_busy_q, prev_busy_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        busy_fall;
   logic        grant_data;

   assign busy_fall  = prev_busy_q & ~mem_busy;
   // On a tie the side that did not win last time is granted.
   assign grant_data = d_req & (~f_req | ~last_q);

   // NOTE: state flops use non-blocking assignments so every register samples
   // the pre-edge value of its _d input, independent of statement order.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         op_q        <= 2'b00;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         prev_busy_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         prev_busy_q <= prev_busy_d;
         cnt_q       <= cnt_d;
      end
   end

   // NOTE: every variable gets a default at the top of the block, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      prev_busy_d = mem_busy;

      case (state_q)
         S_IDLE: begin
            if (f_req || d_req) begin
               owner_d = grant_data;
               cnt_d   = '0;
               state_d = S_ACCESS;
               if (grant_data) begin
                  addr_d = d_addr;
                  if (d_write) begin
                     op_d    = RWI_WRITE;
                     wdata_d = d_wdata;
                  end else begin
                     op_d    = RWI_READ;
                     wdata_d = '0;
                  end
               end else begin
                  op_d    = RWI_FETCH;
                  addr_d  = f_addr;
                  wdata_d = '0;
               end
            end
         end

         S_ACCESS: begin
            cnt_d = cnt_q + 8'd1;
            // A completion in the timeout cycle still counts as a clean finish.
            if (busy_fall) begin
               rdata_d = (op_q == RWI_WRITE) ? 32'd0 : mem_rdata;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_d == TIMEOUT_CNT) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end

         S_RESP: begin
            last_d  = owner_q;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_rwi   = 2'b00;
      mem_addr  = '0;
      mem_wdata = '0;
      f_done    = 1'b0;
      d_done    = 1'b0;
      err       = 1'b0;

      case (state_q)
         S_ACCESS: begin
            mem_rwi   = op_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
         end
         S_RESP: begin
            f_done = ~owner_q;
            d_done = owner_q;
            err    = err_q;
         end
         default: ;
      endcase
   end

   assign rdata  = rdata_q;
   assign active = (state_q != S_IDLE);

endmodule

// File: tb/tb_t07_mem_arbiter.sv
// Scoreboard bench for t07_mem_arbiter: a transaction-level model predicts each grant,
// its bus cycles and its completion; a separate monitor compares the DUT every cycle.
module tb_t07_mem_arbiter;

   localparam int TO = 6;

   logic        clk = 1'b0;
   logic        nrst;
   logic        f_req, d_req, d_write, mem_busy;
   logic [31:0] f_addr, d_addr, d_wdata, mem_rdata;
   logic [1:0]  mem_rwi;
   logic [31:0] mem_addr, mem_wdata, rdata;
   logic        f_done, d_done, err, active;

   t07_mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .f_req     (f_req),
      .f_addr    (f_addr),
      .d_req     (d_req),
      .d_write   (d_write),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .mem_busy  (mem_busy),
      .mem_rdata (mem_rdata),
      .mem_rwi   (mem_rwi),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .f_done    (f_done),
      .d_done    (d_done),
      .rdata     (rdata),
      .err       (err),
      .active    (active)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_data;
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          err;
      int          start;
      int          done_cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] last_rdata = '0;
   bit          mon_en = 1'b0;

   // reference-model state
   bit          f_gr = 1'b0, d_gr = 1'b0;
   int          f_done_at = 0, d_done_at = 0;
   int          free_at = 1 << 30;
   bit          last_data_m = 1'b1;
   int          p_raise = 0, p_reissue = 0;
   int          force_k = 0;
   bit          force_data_en = 1'b0;
   logic [31:0] force_data = '0;
   bit          force_spur = 1'b0;
   int          acc_start = -100, acc_k = 0, acc_len = 0;
   logic [31:0] acc_data = '0;
   int          n_grants = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rwi"},   32'(mem_rwi), 32'd0);
      check({tag, "_addr"},  mem_addr,     32'd0);
      check({tag, "_wdata"}, mem_wdata,    32'd0);
      check({tag, "_rdata"}, rdata,        32'd0);
      check({tag, "_flags"}, {28'd0, f_done, d_done, err, active}, 32'd0);
   endtask

   task automatic new_f();
      f_req  = 1'b1;
      f_addr = $urandom;
   endtask

   task automatic new_d();
      d_req   = 1'b1;
      d_write = 1'($urandom_range(1, 0));
      d_addr  = $urandom;
      d_wdata = $urandom;
   endtask

   // One model cycle: requesters, arbitration, expected transaction, memory responder.
   task automatic cycle_body();
      int   c, k, len;
      bit   pick_d, grant_now;
      exp_t e;
      c = cyc;

      if (f_gr && c == f_done_at) begin
         f_gr = 1'b0;
         if (int'($urandom_range(99, 0)) < p_reissue) new_f(); else f_req = 1'b0;
      end
      if (d_gr && c == d_done_at) begin
         d_gr = 1'b0;
         if (int'($urandom_range(99, 0)) < p_reissue) new_d(); else d_req = 1'b0;
      end
      if (!f_req && int'($urandom_range(99, 0)) < p_raise) new_f();
      if (!d_req && int'($urandom_range(99, 0)) < p_raise) new_d();

      grant_now = 1'b0;
      if (c >= free_at && (f_req || d_req)) begin
         pick_d = d_req && (!f_req || !last_data_m);
         k = (force_k > 0) ? force_k : int'($urandom_range(TO + 2, 1));
         force_k = 0;
         len = (k < TO) ? k : TO;
         acc_data = force_data_en ? force_data : $urandom;
         force_data_en = 1'b0;
         e.is_data  = pick_d;
         e.start    = c + 1;
         e.done_cyc = c + len + 1;
         e.err      = (k > TO);
         if (pick_d) begin
            e.op    = d_write ? 2'b01 : 2'b10;
            e.addr  = d_addr;
            e.wdata = d_write ? d_wdata : 32'd0;
            e.rdata = (k > TO || d_write) ? 32'd0 : acc_data;
            d_gr = 1'b1;
            d_done_at = e.done_cyc;
         end else begin
            e.op    = 2'b11;
            e.addr  = f_addr;
            e.wdata = 32'd0;
            e.rdata = (k > TO) ? 32'd0 : acc_data;
            f_gr = 1'b1;
            f_done_at = e.done_cyc;
         end
         sb_q.push_back(e);
         acc_start   = c + 1;
         acc_k       = k;
         acc_len     = len;
         free_at     = e.done_cyc + 1;
         last_data_m = pick_d;
         grant_now   = 1'b1;
         n_grants++;
      end

      mem_busy  = 1'b1;
      mem_rdata = $urandom;
      if (acc_k <= TO && c == acc_start + acc_k - 1) begin
         mem_busy  = 1'b0;
         mem_rdata = acc_data;
      end else if (!grant_now && (c < acc_start || c >= acc_start + acc_len) &&
                   (force_spur || $urandom_range(7, 0) == 0)) begin
         mem_busy = 1'b0;
      end
      force_spur = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
      cycle_body();
   endtask

   task automatic wait_free();
      int n;
      n = 0;
      while (n < 400 && (f_req || d_req || cyc < free_at)) begin
         tick();
         n++;
      end
      vectors++;
      if (n >= 400) begin
         miscompares++;
         $display("FAIL wait_free @cycle %0d: still busy after %0d cycles, expected idle", cyc, n);
      end
   endtask

   task automatic monitor_cycle();
      exp_t e;
      if (sb_q.size() > 0 && cyc >= sb_q[0].start && cyc < sb_q[0].done_cyc) begin
         e = sb_q[0];
         check("access_rwi",   32'(mem_rwi), 32'(e.op));
         check("access_addr",  mem_addr,     e.addr);
         check("access_wdata", mem_wdata,    e.wdata);
         check("access_flags", {28'd0, active, f_done, d_done, err}, 32'h8);
         check("access_rdata_hold", rdata, last_rdata);
      end else if (sb_q.size() > 0 && cyc == sb_q[0].done_cyc) begin
         e = sb_q.pop_front();
         check("done_owner", {30'd0, f_done, d_done}, e.is_data ? 32'd1 : 32'd2);
         check("done_err",   32'(err), 32'(e.err));
         check("done_rdata", rdata,    e.rdata);
         check("resp_rwi",   32'(mem_rwi), 32'd0);
         check("resp_bus",   mem_addr | mem_wdata, 32'd0);
         check("resp_active", 32'(active), 32'd1);
         last_rdata = e.rdata;
      end else begin
         check("idle_flags", {28'd0, active, f_done, d_done, err}, 32'd0);
         check("idle_rwi",   32'(mem_rwi), 32'd0);
         check("idle_bus",   mem_addr | mem_wdata, 32'd0);
         check("idle_rdata_hold", rdata, last_rdata);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) monitor_cycle();
   end

   task automatic reset_mid_access();
      wait_free();
      @(negedge clk);
      d_req = 1'b1; d_write = 1'b0; d_addr = 32'h4000_0010; d_wdata = $urandom;
      force_k = TO + 2;
      cycle_body();
      tick();
      tick();
      #2;
      mon_en = 1'b0;
      nrst = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      sb_q.delete();
      f_gr = 1'b0; d_gr = 1'b0;
      free_at = 1 << 30;
      acc_start = -100; acc_k = 0; acc_len = 0;
      last_data_m = 1'b1;
      last_rdata = '0;
      repeat (2) begin
         @(negedge clk);
         check("mid_rst_hold_done", {30'd0, f_done, d_done}, 32'd0);
         check("mid_rst_hold_active", 32'(active), 32'd0);
      end
      @(negedge clk);
      nrst = 1'b1;
      free_at = cyc;
      mon_en = 1'b1;
      cycle_body();
      wait_free();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nrst = 1'b0;
      f_req = 1'b0; f_addr = '0;
      d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
      mem_busy = 1'b1; mem_rdata = '0;
      #1;
      check_reset_outputs("por");
      repeat (3) @(negedge clk);

      // Tie straight out of reset, then forced alternation via immediate re-requests.
      nrst = 1'b1;
      free_at = cyc;
      mon_en = 1'b1;
      f_req = 1'b1; f_addr = 32'h0000_0400;
      d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_2000; d_wdata = $urandom;
      p_reissue = 100;
      cycle_body();
      for (int n = 0; n < 200 && n_grants < 5; n++) tick();
      p_reissue = 0;
      wait_free();

      // Single fetch with completion on the fifth ACCESS cycle.
      @(negedge clk);
      f_req = 1'b1; f_addr = 32'h0000_0100;
      force_k = 5; force_data = 32'hCAFE_F00D; force_data_en = 1'b1;
      cycle_body();
      wait_free();

      // Store.
      @(negedge clk);
      d_req = 1'b1; d_write = 1'b1; d_addr = 32'h0000_3004; d_wdata = 32'h1234_5678;
      force_k = 3;
      cycle_body();
      wait_free();

      // Timeout with no falling edge.
      @(negedge clk);
      f_req = 1'b1; f_addr = 32'h0000_0800;
      force_k = TO + 2;
      cycle_body();
      wait_free();

      // Falling edge exactly on the timeout cycle.
      @(negedge clk);
      d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_5000;
      force_k = TO;
      cycle_body();
      wait_free();

      // Minimum latency.
      @(negedge clk);
      f_req = 1'b1; f_addr = 32'h0000_0C00;
      force_k = 1;
      cycle_body();
      wait_free();

      // Spurious busy fall while idle.
      @(negedge clk);
      force_spur = 1'b1;
      cycle_body();
      repeat (3) tick();

      reset_mid_access();

      // Random traffic.
      p_raise = 30;
      p_reissue = 50;
      repeat (3000) tick();
      p_raise = 0;
      p_reissue = 0;
      wait_free();
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
